cordic_job_controller: RTL

CORDIC_JOB_CONTROLLER -- requirements
Module: cordic_job_controller

---
 rtl/cordic_job_controller.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/cordic_job_controller.sv
// Job controller for a fixed-latency CORDIC pipeline: issue register,
// in-flight tracking, mode draining and a credit-protected result FIFO.
module cordic_job_controller #(
  parameter int LATENCY    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_x,
  input  logic [31:0] in_y,
  input  logic [31:0] in_angle,
  input  logic [1:0]  in_mode,
  output logic [31:0] cordic_x,
  output logic [31:0] cordic_y,
  output logic [31:0] cordic_angle,
  output logic [1:0]  cordic_mode,
  input  logic [31:0] cordic_rx,
  input  logic [31:0] cordic_ry,
  input  logic [31:0] cordic_rangle,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_x,
  output logic [31:0] out_y,
  output logic [31:0] out_angle,
  output logic [1:0]  out_mode,
  output logic        busy
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + LATENCY + 2) + 1;

  typedef enum logic {RUN, DRAIN} state_t;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] a;
    logic [1:0]  m;
  } res_t;

  state_t              r_state;
  logic [1:0]          r_cur_mode;
  logic [1:0]          r_tgt_mode;
  logic                r_issue_v;
  logic [LATENCY-1:0]  r_sr;
  logic [CW-1:0]       r_inflight;
  logic [31:0]         r_cx;
  logic [31:0]         r_cy;
  logic [31:0]         r_ca;
  res_t                r_mem [FIFO_DEPTH];
  logic [PW-1:0]       r_wr;
  logic [PW-1:0]       r_rd;
  logic [CW-1:0]       r_mcnt;
  logic                r_ov;
  res_t                r_out;

  logic [1:0]          w_mode;
  logic [CW-1:0]       w_occ;
  logic                w_accept;
  logic                w_tail;
  logic                w_pop;
  logic                w_load;

  assign w_mode   = (in_mode == 2'b01) ? 2'b00 : in_mode;
  // Output register counts as occupancy so credits cover every slot
  assign w_occ    = r_mcnt + CW'(r_ov);
  assign w_tail   = r_sr[LATENCY-1];
  assign w_pop    = r_ov & out_ready;
  assign w_load   = (r_mcnt != '0) & (~r_ov | out_ready);
  assign in_ready = reset_n
                  & (r_state == RUN)
                  & (w_mode == r_cur_mode)
                  & ((r_inflight + w_occ) < CW'(FIFO_DEPTH));
  assign w_accept = in_valid & in_ready;

  assign cordic_x     = r_cx;
  assign cordic_y     = r_cy;
  assign cordic_angle = r_ca;
  assign cordic_mode  = r_cur_mode;
  assign out_valid    = r_ov;
  assign out_x        = r_out.x;
  assign out_y        = r_out.y;
  assign out_angle    = r_out.a;
  assign out_mode     = r_out.m;
  assign busy         = (r_inflight != '0) | (w_occ != '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= RUN;
      r_cur_mode <= 2'b10;
      r_tgt_mode <= 2'b10;
    end else begin
      unique case (r_state)
        RUN: begin
          if (in_valid && (w_mode != r_cur_mode)) begin
            r_state    <= DRAIN;
            r_tgt_mode <= w_mode;
          end
        end
        DRAIN: begin
          if (r_inflight == '0) begin
            r_cur_mode <= r_tgt_mode;
            r_state    <= RUN;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_issue_v  <= 1'b0;
      r_sr       <= '0;
      r_inflight <= '0;
      r_cx       <= '0;
      r_cy       <= '0;
      r_ca       <= '0;
    end else begin
      r_issue_v <= w_accept;
      r_sr      <= LATENCY'({r_sr, r_issue_v});
      if (w_accept) begin
        r_cx <= in_x;
        r_cy <= in_y;
        r_ca <= in_angle;
      end
      unique case ({w_accept, w_tail})
        2'b10:   r_inflight <= r_inflight + CW'(1);
        2'b01:   r_inflight <= r_inflight - CW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_tail) begin
      r_mem[r_wr] <= '{x: cordic_rx, y: cordic_ry,
                       a: cordic_rangle, m: r_cur_mode};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_mcnt <= '0;
      r_ov   <= 1'b0;
      r_out  <= '0;
    end else begin
      if (w_tail) r_wr <= r_wr + PW'(1);
      if (w_load) begin
        r_out <= r_mem[r_rd];
        r_ov  <= 1'b1;
        r_rd  <= r_rd + PW'(1);
      end else if (w_pop) begin
        r_ov <= 1'b0;
      end
      unique case ({w_tail, w_load})
        2'b10:   r_mcnt <= r_mcnt + CW'(1);
        2'b01:   r_mcnt <= r_mcnt - CW'(1);
        default: r_mcnt <= r_mcnt;
      endcase
    end
  end
endmodule
